// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer game sequencer.
package reaction_pkg;

  typedef enum logic [1:0] {
    START  = 2'd0,
    READY  = 2'd1,
    PLAY   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [3:0]  BLANK     = 4'hF;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter, synchronous clear, saturating at 99.
module bcd2_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       at_max
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc && !at_max) begin
      if (ones_q == 4'd9) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens   = tens_q;
  assign ones   = ones_q;
  assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-timer game sequencer: button sync/edge, LFSR delay, BCD reaction count.
// Optional best-time register enabled by defining REACTION_BEST_EN.
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned MIN_DELAY_TICKS = 10,
  parameter int unsigned DELAY_BITS      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] state,
  output logic       go,
  output logic       false_start,
  output logic       timeout,
  output logic [3:0] best_tens,
  output logic [3:0] best_ones
);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        fs_q, fs_d;
  logic        to_q, to_d;
  logic [15:0] lfsr_q;
  logic        sync1_q, sync2_q, prev_q, press_q;
  logic        cnt_clr, cnt_inc, cnt_max;
  logic [3:0]  cnt_tens, cnt_ones;
  logic [7:0]  wait_load;

  // press is registered so it lands one cycle after the edge detector sees the rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= sync2_q & ~prev_q;
      lfsr_q  <= lfsr_next(lfsr_q);
    end
  end

  assign wait_load = 8'(MIN_DELAY_TICKS) + 8'(lfsr_q[DELAY_BITS-1:0]);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fs_d    = fs_q;
    to_d    = to_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      START: begin
        cnt_clr = 1'b1;
        if (press_q) begin
          wait_d  = wait_load;
          state_d = READY;
        end
      end
      READY: begin
        if (press_q) begin
          fs_d    = 1'b1;
          state_d = FINISH;
        end else if (tick) begin
          wait_d = wait_q - 8'd1;
          if (wait_q == 8'd1) begin
            cnt_clr = 1'b1;
            state_d = PLAY;
          end
        end
      end
      PLAY: begin
        if (press_q) begin
          state_d = FINISH;
        end else if (tick) begin
          if (cnt_max) begin
            to_d    = 1'b1;
            state_d = FINISH;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      FINISH: begin
        if (press_q) begin
          fs_d    = 1'b0;
          to_d    = 1'b0;
          state_d = START;
        end
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= START;
      wait_q  <= '0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fs_q    <= fs_d;
      to_q    <= to_d;
    end
  end

  bcd2_counter u_count (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .tens   (cnt_tens),
    .ones   (cnt_ones),
    .at_max (cnt_max)
  );

  assign state       = state_q;
  assign go          = (state_q == PLAY);
  assign false_start = fs_q;
  assign timeout     = to_q;
  assign tens        = (state_q == START || state_q == READY) ? BLANK : cnt_tens;
  assign ones        = (state_q == START || state_q == READY) ? BLANK : cnt_ones;

`ifdef REACTION_BEST_EN
  logic [7:0] best_q;
  logic       best_upd;

  // only a press out of PLAY is a valid time; false starts and timeouts never qualify
  assign best_upd = (state_q == PLAY) && press_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_q <= 8'h99;
    end else if (best_upd && ({cnt_tens, cnt_ones} < best_q)) begin
      best_q <= {cnt_tens, cnt_ones};
    end
  end

  assign best_tens = best_q[7:4];
  assign best_ones = best_q[3:0];
`else
  assign best_tens = BLANK;
  assign best_ones = BLANK;
`endif

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Self-checking bench for reaction_game_ctrl: randomized tick spacing and round lengths
// against a round-level reference model.
module tb_reaction_game_ctrl;

  localparam int MIN_T = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       btn = 1'b0;
  logic [3:0] tens, ones, best_tens, best_ones;
  logic [1:0] state;
  logic       go, false_start, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  reaction_game_ctrl #(.MIN_DELAY_TICKS(MIN_T), .DELAY_BITS(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .btn         (btn),
    .tens        (tens),
    .ones        (ones),
    .state       (state),
    .go          (go),
    .false_start (false_start),
    .timeout     (timeout),
    .best_tens   (best_tens),
    .best_ones   (best_ones)
  );

  always #5 clk = ~clk;

  // Reference pseudo-random source: polynomial x^16+x^14+x^13+x^11, seeded at reset
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  int best_n = 99;
  int exp_wait;
  logic [15:0] lp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      repeat ($urandom_range(0, 2)) cyc();
    end
  endtask

  // Press lands on the 4th edge after btn rises; optionally a tick on that same edge
  task automatic do_press(input bit with_tick);
    btn = 1'b1;
    repeat (3) cyc();
    lp = m_lfsr;
    tick = with_tick;
    cyc();
    tick = 1'b0;
    btn = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic check_best(input string tag);
`ifdef REACTION_BEST_EN
    check({tag, "_best_t"}, 32'(best_tens), 32'(best_n / 10));
    check({tag, "_best_o"}, 32'(best_ones), 32'(best_n % 10));
`else
    check({tag, "_best_t"}, 32'(best_tens), 32'hF);
    check({tag, "_best_o"}, 32'(best_ones), 32'hF);
`endif
  endtask

  task automatic check_disp(input string tag, input int n);
    check({tag, "_tens"}, 32'(tens), 32'(n / 10));
    check({tag, "_ones"}, 32'(ones), 32'(n % 10));
  endtask

  task automatic check_start(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_tens"}, 32'(tens), 32'hF);
    check({tag, "_ones"}, 32'(ones), 32'hF);
    check({tag, "_flags"}, {29'd0, go, false_start, timeout}, 32'd0);
  endtask

  task automatic to_play(input string tag);
    do_press(1'b0);
    exp_wait = MIN_T + int'(lp & 16'h1F);
    check({tag, "_ready"}, 32'(state), 32'd1);
    ticks(exp_wait - 1);
    check({tag, "_still_ready"}, 32'(state), 32'd1);
    check({tag, "_ready_blank"}, 32'(tens), 32'hF);
    ticks(1);
    check({tag, "_play"}, 32'(state), 32'd2);
    check({tag, "_go"}, 32'(go), 32'd1);
    check_disp({tag, "_zero"}, 0);
  endtask

  task automatic timed_round(input string tag, input int n, input bit press_tick);
    to_play(tag);
    ticks(n);
    check_disp({tag, "_count"}, n);
    do_press(press_tick);
    if (n < best_n) best_n = n;
    check({tag, "_finish"}, 32'(state), 32'd3);
    check_disp({tag, "_final"}, n);
    check({tag, "_flags"}, {29'd0, go, false_start, timeout}, 32'd0);
    check_best(tag);
    ticks(2);
    check_disp({tag, "_hold"}, n);
    do_press(1'b0);
    check_start({tag, "_restart"});
  endtask

  initial begin
    int trans;
    logic [1:0] prev_st;

    repeat (3) cyc();
    check_start("reset");
    check_best("reset");
    reset = 1'b0;
    cyc();

    timed_round("r23", 23, 1'b0);
    timed_round("r15", 15, 1'b0);
    timed_round("r40", 40, 1'b0);

    // false start after 4 READY ticks
    do_press(1'b0);
    ticks(4);
    do_press(1'b0);
    check("fs_state", 32'(state), 32'd3);
    check("fs_flag", 32'(false_start), 32'd1);
    check_disp("fs_disp", 0);
    check_best("fs");
    do_press(1'b0);
    check_start("fs_restart");

    // press coincident with the final READY tick
    do_press(1'b0);
    exp_wait = MIN_T + int'(lp & 16'h1F);
    ticks(exp_wait - 1);
    do_press(1'b1);
    check("fs_last_state", 32'(state), 32'd3);
    check("fs_last_flag", 32'(false_start), 32'd1);
    do_press(1'b0);

    // press coincident with a tick at count 09
    timed_round("sim09", 9, 1'b1);

    for (int r = 0; r < 3; r++) timed_round("rand", int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)));

    // timeout
    to_play("to");
    ticks(99);
    check("to_play", 32'(state), 32'd2);
    check_disp("to_99", 99);
    ticks(1);
    check("to_state", 32'(state), 32'd3);
    check("to_flag", 32'(timeout), 32'd1);
    check("to_fs", 32'(false_start), 32'd0);
    check_disp("to_disp", 99);
    check_best("to");
    ticks(3);
    check_disp("to_hold", 99);
    do_press(1'b0);
    check_start("to_restart");

    // held button yields one transition
    trans = 0;
    prev_st = state;
    btn = 1'b1;
    repeat (3) cyc();
    lp = m_lfsr;
    for (int i = 0; i < 47; i++) begin
      cyc();
      if (state != prev_st) trans++;
      prev_st = state;
    end
    btn = 1'b0;
    repeat (3) cyc();
    check("held_trans", 32'(trans), 32'd1);
    check("held_state", 32'(state), 32'd1);
    exp_wait = MIN_T + int'(lp & 16'h1F);
    ticks(exp_wait);
    check("held_play", 32'(state), 32'd2);
    ticks(37);
    check_disp("pre_reset", 37);

    // asynchronous reset mid-PLAY
    reset = 1'b1;
    #1;
    check_start("async_reset");
    cyc();
    check_start("reset_hold");
    best_n = 99;
    check_best("reset2");
    reset = 1'b0;
    cyc();
    timed_round("post", 5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_game_ctrl.md
# reaction_game_ctrl

Game sequencer for the Tiny Tapeout reaction-timer design. It reads the player button, waits a pseudo-random delay, then times the reaction in tenths of a second as two BCD digits for the dual seven-segment driver. It sits between the `ui_in` button/switch inputs, the 0.1 s tick from the clock divider, and the display mux. The segment decode and display multiplexing stay outside this block.

## Interface
- `MIN_DELAY_TICKS`, default 10: minimum wait in READY, in ticks. Legal range 1..200.
- `DELAY_BITS`, default 5: random extra wait is `lfsr[DELAY_BITS-1:0]` ticks. Legal range 1..5.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high.
- `tick`  in  1: one-`clk` pulse every 0.1 s.
- `btn`  in  1: raw player button, asynchronous to `clk`, active-high.
- `tens`  out  4: BCD tens digit; `4'hF` means blank.
- `ones`  out  4: BCD ones digit; `4'hF` means blank.
- `state`  out  2: current `state_t`.
- `go`  out  1: high throughout PLAY.
- `false_start`  out  1: sticky in FINISH when the press came during READY.
- `timeout`  out  1: sticky in FINISH when the count saturated at 99.
- `best_tens`, `best_ones`  out  4 each: best-time digits (see Configuration).

## Operation
- **Button path:** `btn` passes through a 2-flop synchronizer, then a rising-edge detector, producing `press`, a 1-cycle pulse. A held button yields exactly one `press`.
- **LFSR:** 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every `clk`. Reset seed is `16'hACE1`; the state is never all-zero.
- **START:**
  - Outputs: `tens`=`ones`=F, all flags 0.
  - On `press`: load `wait_cnt` = `MIN_DELAY_TICKS` + `lfsr[DELAY_BITS-1:0]` (8-bit), then go to READY.
- **READY:**
  - Display stays blank.
  - On `tick`: decrement `wait_cnt`.
  - On `tick` while `wait_cnt`==1: go to PLAY and clear the BCD count to 00.
  - On `press`: go to FINISH with `false_start`=1 and display 00.
  - `press` and the final `tick` in the same cycle: `press` wins, so the result is a false start.
- **PLAY:**
  - Outputs: `go`=1, display shows the count.
  - On `tick`: BCD increment. Ones wraps 9→0 with a carry into tens.
  - On `tick` at 99: the count stays 99, go to FINISH with `timeout`=1.
  - On `press`: freeze the count and go to FINISH.
  - `press` and `tick` in the same cycle: `press` wins and the count does not increment.
- **FINISH:**
  - Display and flags hold.
  - On `press`: go to START, which blanks the display and clears the flags.
- **Reset:**
  - Effective immediately in any state, mid-game included.
  - state=START, `tens`=`ones`=F, `go`=`false_start`=`timeout`=0, LFSR=seed, `wait_cnt`=0, synchronizer flops=0.

## Timing
- All outputs are registered and change only on `clk` edges. There are no combinational input-to-output paths.
- `btn` rising before edge n produces `press` in the cycle after edge n+2. The state change is visible after edge n+3.
- PLAY is entered on the `clk` edge that samples the qualifying `tick`.
- READY lasts exactly `wait_cnt` ticks.
- Each count increment appears one `clk` after its `tick`.
- `tick` is ignored in START and FINISH.

## Configuration
- `REACTION_BEST_EN` defined:
  - Adds a best-time register, reset to 9/9.
  - On entry to FINISH with no `false_start` and no `timeout`, the register updates if the new {tens,ones} is lower than the stored best.
  - `best_tens`/`best_ones` show the register.
- `REACTION_BEST_EN` undefined:
  - No register is built; `best_tens`/`best_ones` are tied to `4'hF`.
  - All other behaviour is identical.

## Structure
- Package `reaction_pkg`:
  - `state_t` enum {START=0, READY=1, PLAY=2, FINISH=3}.
  - `BLANK` = `4'hF`.
  - `LFSR_SEED` = `16'hACE1`.
  - `LFSR_TAPS`.
- Sub-module `bcd2_counter`:
  - Inputs: `clk`, `reset`, `clr`, `inc`.
  - Outputs: `tens`, `ones`, and `at_max` (high at 99).
  - Saturates at 99.
- The FSM, synchronizer, edge detector and LFSR live in `reaction_game_ctrl`.

## Test plan
- **Reset state:** reset asserted mid-PLAY with count 37 → the next cycle shows START, `tens`=`ones`=F, `go`=0.
- **Normal round:** defaults, seed `ACE1` (low 5 bits = 1, so `wait_cnt`=11 if sampled on the first cycle). Press, then 11 ticks → PLAY. 23 ticks then press → FINISH with 2/3, `go`=0, both flags 0.
- **False start:** press in READY after 4 ticks → FINISH, `false_start`=1, display 0/0.
- **Timeout:** in PLAY, 100 ticks with no press → count 9/9, `timeout`=1, then FINISH.
- **Simultaneous events:** `press` coincident with `tick` at count 09 → freezes at 0/9, not 1/0. `press` coincident with the final READY `tick` → `false_start`=1.
- **Held button and best time:** button held 50 cycles → exactly one transition. With `REACTION_BEST_EN`, rounds of 23 then 15 → best 1/5. A later round of 40 leaves the best at 1/5.
